// File: rtl/sb_pkg.sv
// Shared sideband definitions: LTSM state enums, message enums, header field
// positions and the receive-side decode table.
package sb_pkg;

  typedef enum logic [3:0] {
    RESET      = 4'd0,
    SBINIT     = 4'd1,
    MBINIT     = 4'd2,
    MBTRAIN    = 4'd3,
    LINKINIT   = 4'd4,
    ACTIVE     = 4'd5,
    PHYRETRAIN = 4'd6,
    TRAINERROR = 4'd7
  } e_states;

  typedef enum logic [3:0] {
    PARAM      = 4'd0,
    CAL        = 4'd1,
    REPAIRCLK  = 4'd2,
    REPAIRVAL  = 4'd3,
    REVERSALMB = 4'd4,
    REPAIRMB   = 4'd5
  } e_sub_states_MBINIT;

  typedef enum logic [3:0] {
    SBINIT_DONE_REQ     = 4'd1,
    SBINIT_DONE_RESP    = 4'd2,
    SBINIT_OUT_OF_RESET = 4'd3
  } e_msg_sbinit;

  typedef enum logic [3:0] {
    PARAM_CONFIG_REQ  = 4'd1,
    PARAM_CONFIG_RESP = 4'd2
  } e_msg_param;

  typedef enum logic [3:0] {
    CAL_DONE_REQ  = 4'd1,
    CAL_DONE_RESP = 4'd2
  } e_msg_cal;

  localparam logic [4:0] OPC_MSG_NODATA = 5'b10010;
  localparam logic [4:0] OPC_MSG_DATA   = 5'b11011;

  localparam int OPC_LSB     = 0;
  localparam int OPC_MSB     = 4;
  localparam int CODE_LSB    = 14;
  localparam int CODE_MSB    = 21;
  localparam int SUBCODE_LSB = 32;
  localparam int SUBCODE_MSB = 39;
  localparam int INFO_LSB    = 40;
  localparam int INFO_MSB    = 55;
  localparam int DP_BIT      = 62;
  localparam int CP_BIT      = 63;

  typedef struct packed {
    logic       hit;
    logic [3:0] msg_no;
    logic       is_resp;
  } sb_dec_t;

  // Sub-state only qualifies the lookup while in MBINIT.
  function automatic sb_dec_t sb_decode(input e_states    state,
                                        input logic [3:0] sub_state,
                                        input logic [7:0] code,
                                        input logic [7:0] subcode);
    sb_dec_t r;
    r = '0;
    case (state)
      SBINIT: begin
        case ({code, subcode})
          16'h9100: r = '{1'b1, 4'(SBINIT_OUT_OF_RESET), 1'b0};
          16'h9501: r = '{1'b1, 4'(SBINIT_DONE_REQ),     1'b0};
          16'h9A01: r = '{1'b1, 4'(SBINIT_DONE_RESP),    1'b1};
          default:  r = '0;
        endcase
      end
      MBINIT: begin
        if (sub_state == 4'(PARAM)) begin
          case ({code, subcode})
            16'hA500: r = '{1'b1, 4'(PARAM_CONFIG_REQ),  1'b0};
            16'hAA00: r = '{1'b1, 4'(PARAM_CONFIG_RESP), 1'b1};
            default:  r = '0;
          endcase
        end else if (sub_state == 4'(CAL)) begin
          case ({code, subcode})
            16'h9502: r = '{1'b1, 4'(CAL_DONE_REQ),  1'b0};
            16'h9A02: r = '{1'b1, 4'(CAL_DONE_RESP), 1'b1};
            default:  r = '0;
          endcase
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sb_rx_parity_chk.sv
// Combinational even-parity check of a sideband word: CP over header bits
// [61:0], DP over a full data word against the DP bit taken from its header.
module sb_rx_parity_chk
  import sb_pkg::*;
(
  input  logic [63:0] word,
  input  logic        dp_bit,
  output logic        cp_err,
  output logic        dp_err
);

  assign cp_err = ^{word[CP_BIT], word[DP_BIT-1:0]};
  assign dp_err = (^word) ^ dp_bit;

endmodule

// File: rtl/sb_rx_wrapper.sv
// Sideband RX wrapper: SBINIT pattern hunt, header/payload parsing with
// parity checks, and table decode into msg_no/msg_info/data for the LTSM.
module sb_rx_wrapper
  import sb_pkg::*;
#(
  parameter logic [63:0] PATTERN   = 64'hAAAA_AAAA_AAAA_AAAA,
  parameter int          PAT_COUNT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_de_ser_done,
  input  logic [63:0] i_deser_data,
  input  e_states     i_state,
  input  logic [3:0]  i_sub_state,
  output logic        o_rx_sb_pattern_samp_done,
  output logic        o_msg_valid,
  output logic [3:0]  o_msg_no,
  output logic [15:0] o_msg_info,
  output logic        o_data_valid,
  output logic [15:0] o_data_bus,
  output logic        o_rx_sb_rsp_delivered,
  output logic        o_parity_err,
  output logic        o_decode_err
);

  localparam logic [1:0] ST_HUNT = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam int CNT_W = $clog2(PAT_COUNT + 1);

  logic [1:0]       fsm_reg, fsm_next;
  logic [CNT_W-1:0] pat_cnt_reg, pat_cnt_next;
  e_states          prev_state_reg;

  // Header fields held across the wait for the payload word.
  logic [7:0]  code_reg, code_next;
  logic [7:0]  subcode_reg, subcode_next;
  logic [15:0] info_reg, info_next;
  logic        dp_reg, dp_next;

  logic        samp_done_reg, samp_done_next;
  logic        msg_valid_reg, msg_valid_next;
  logic [3:0]  msg_no_reg, msg_no_next;
  logic [15:0] msg_info_reg, msg_info_next;
  logic        data_valid_reg, data_valid_next;
  logic [15:0] data_bus_reg, data_bus_next;
  logic        rsp_reg, rsp_next;
  logic        parity_err_reg, parity_err_next;
  logic        decode_err_reg, decode_err_next;

  logic        cp_err;
  logic        dp_err;
  logic        abort;
  logic [4:0]  opcode;
  logic [7:0]  dec_code;
  logic [7:0]  dec_subcode;
  logic [15:0] dec_info;
  sb_dec_t     dec;

  sb_rx_parity_chk u_parity_chk (
    .word   (i_deser_data),
    .dp_bit (dp_reg),
    .cp_err (cp_err),
    .dp_err (dp_err)
  );

  assign abort  = (i_state != prev_state_reg);
  assign opcode = i_deser_data[OPC_MSB:OPC_LSB];

  // In ST_DATA the code pair comes from the latched header, else from the word.
  always_comb begin
    dec_code    = i_deser_data[CODE_MSB:CODE_LSB];
    dec_subcode = i_deser_data[SUBCODE_MSB:SUBCODE_LSB];
    dec_info    = i_deser_data[INFO_MSB:INFO_LSB];
    if (fsm_reg == ST_DATA) begin
      dec_code    = code_reg;
      dec_subcode = subcode_reg;
      dec_info    = info_reg;
    end
  end

  assign dec = sb_decode(i_state, i_sub_state, dec_code, dec_subcode);

  always_comb begin
    fsm_next        = fsm_reg;
    pat_cnt_next    = pat_cnt_reg;
    code_next       = code_reg;
    subcode_next    = subcode_reg;
    info_next       = info_reg;
    dp_next         = dp_reg;
    samp_done_next  = 1'b0;
    msg_valid_next  = 1'b0;
    msg_no_next     = msg_no_reg;
    msg_info_next   = msg_info_reg;
    data_valid_next = 1'b0;
    data_bus_next   = data_bus_reg;
    rsp_next        = 1'b0;
    parity_err_next = 1'b0;
    decode_err_next = 1'b0;

    if (abort) begin
      // A state change wins over a word arriving in the same cycle.
      fsm_next     = (i_state == SBINIT) ? ST_HUNT : ST_HDR;
      pat_cnt_next = '0;
    end else if (i_de_ser_done) begin
      case (fsm_reg)
        ST_HUNT: begin
          if (i_deser_data == PATTERN) begin
            if (pat_cnt_reg == CNT_W'(PAT_COUNT - 1)) begin
              samp_done_next = 1'b1;
              pat_cnt_next   = '0;
              fsm_next       = ST_HDR;
            end else begin
              pat_cnt_next = pat_cnt_reg + CNT_W'(1);
            end
          end else begin
            pat_cnt_next = '0;
          end
        end

        ST_HDR: begin
          // Trailing pattern words from the remote are expected here.
          if (i_deser_data == PATTERN) begin
            fsm_next = ST_HDR;
          end else if (cp_err) begin
            parity_err_next = 1'b1;
          end else if (opcode == OPC_MSG_NODATA) begin
            if (dec.hit) begin
              msg_valid_next = 1'b1;
              msg_no_next    = dec.msg_no;
              msg_info_next  = dec_info;
              rsp_next       = dec.is_resp;
            end else begin
              decode_err_next = 1'b1;
            end
          end else if (opcode == OPC_MSG_DATA) begin
            code_next    = dec_code;
            subcode_next = dec_subcode;
            info_next    = dec_info;
            dp_next      = i_deser_data[DP_BIT];
            fsm_next     = ST_DATA;
          end else begin
            decode_err_next = 1'b1;
          end
        end

        ST_DATA: begin
          fsm_next = ST_HDR;
          if (dp_err) begin
            parity_err_next = 1'b1;
          end else if (dec.hit) begin
            msg_valid_next  = 1'b1;
            msg_no_next     = dec.msg_no;
            msg_info_next   = dec_info;
            rsp_next        = dec.is_resp;
            data_valid_next = 1'b1;
            data_bus_next   = i_deser_data[15:0];
          end else begin
            decode_err_next = 1'b1;
          end
        end

        default: fsm_next = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fsm_reg        <= ST_HUNT;
      pat_cnt_reg    <= '0;
      prev_state_reg <= SBINIT;
      code_reg       <= '0;
      subcode_reg    <= '0;
      info_reg       <= '0;
      dp_reg         <= 1'b0;
      samp_done_reg  <= 1'b0;
      msg_valid_reg  <= 1'b0;
      msg_no_reg     <= '0;
      msg_info_reg   <= '0;
      data_valid_reg <= 1'b0;
      data_bus_reg   <= '0;
      rsp_reg        <= 1'b0;
      parity_err_reg <= 1'b0;
      decode_err_reg <= 1'b0;
    end else begin
      fsm_reg        <= fsm_next;
      pat_cnt_reg    <= pat_cnt_next;
      prev_state_reg <= i_state;
      code_reg       <= code_next;
      subcode_reg    <= subcode_next;
      info_reg       <= info_next;
      dp_reg         <= dp_next;
      samp_done_reg  <= samp_done_next;
      msg_valid_reg  <= msg_valid_next;
      msg_no_reg     <= msg_no_next;
      msg_info_reg   <= msg_info_next;
      data_valid_reg <= data_valid_next;
      data_bus_reg   <= data_bus_next;
      rsp_reg        <= rsp_next;
      parity_err_reg <= parity_err_next;
      decode_err_reg <= decode_err_next;
    end
  end

  assign o_rx_sb_pattern_samp_done = samp_done_reg;
  assign o_msg_valid               = msg_valid_reg;
  assign o_msg_no                  = msg_no_reg;
  assign o_msg_info                = msg_info_reg;
  assign o_data_valid              = data_valid_reg;
  assign o_data_bus                = data_bus_reg;
  assign o_rx_sb_rsp_delivered     = rsp_reg;
  assign o_parity_err              = parity_err_reg;
  assign o_decode_err              = decode_err_reg;

endmodule

// File: tb/tb_sb_rx_wrapper.sv
// Directed bench for sb_rx_wrapper: pattern hunt, header/data decode,
// parity and decode errors, state-change abort and reset behaviour.
module tb_sb_rx_wrapper;
  import sb_pkg::*;

  localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;

  logic        clk;
  logic        rst;
  logic        de_ser_done;
  logic [63:0] deser_data;
  e_states     state;
  logic [3:0]  sub_state;
  logic        samp_done;
  logic        msg_valid;
  logic [3:0]  msg_no;
  logic [15:0] msg_info;
  logic        data_valid;
  logic [15:0] data_bus;
  logic        rsp_delivered;
  logic        parity_err;
  logic        decode_err;

  int n_checks = 0;
  int n_errors = 0;

  sb_rx_wrapper #(.PATTERN(PAT), .PAT_COUNT(2)) dut (
    .i_clk                     (clk),
    .i_rst                     (rst),
    .i_de_ser_done             (de_ser_done),
    .i_deser_data              (deser_data),
    .i_state                   (state),
    .i_sub_state               (sub_state),
    .o_rx_sb_pattern_samp_done (samp_done),
    .o_msg_valid               (msg_valid),
    .o_msg_no                  (msg_no),
    .o_msg_info                (msg_info),
    .o_data_valid              (data_valid),
    .o_data_bus                (data_bus),
    .o_rx_sb_rsp_delivered     (rsp_delivered),
    .o_parity_err              (parity_err),
    .o_decode_err              (decode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Header with even CP over [61:0]; the DP bit is supplied by the caller.
  function automatic logic [63:0] mk_hdr(input logic [4:0] opc, input logic [7:0] code,
                                         input logic [7:0] sub, input logic [15:0] info,
                                         input logic dp);
    logic [63:0] w;
    w        = '0;
    w[4:0]   = opc;
    w[21:14] = code;
    w[39:32] = sub;
    w[55:40] = info;
    w[62]    = dp;
    w[63]    = ^w[61:0];
    return w;
  endfunction

  task automatic send(input logic [63:0] w);
    de_ser_done = 1'b1;
    deser_data  = w;
    @(posedge clk);
    #1;
    de_ser_done = 1'b0;
    $display("word %h state %0d sub %0d -> valid %0b no %0d info %h dv %0b data %h rsp %0b samp %0b perr %0b derr %0b",
             w, state, sub_state, msg_valid, msg_no, msg_info, data_valid, data_bus,
             rsp_delivered, samp_done, parity_err, decode_err);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) idle();
    rst = 1'b0;
  endtask

  logic [63:0] w;

  initial begin
    rst         = 1'b1;
    de_ser_done = 1'b0;
    deser_data  = '0;
    state       = SBINIT;
    sub_state   = 4'(PARAM);
    repeat (2) idle();

    check("rst_samp", {63'd0, samp_done}, 64'd0);
    check("rst_valid", {63'd0, msg_valid}, 64'd0);
    check("rst_msg_no", {60'd0, msg_no}, 64'd0);
    check("rst_info", {48'd0, msg_info}, 64'd0);
    check("rst_data_bus", {48'd0, data_bus}, 64'd0);
    check("rst_errs", {62'd0, parity_err, decode_err}, 64'd0);
    rst = 1'b0;

    // Two pattern words
    send(PAT);
    check("pat1_samp", {63'd0, samp_done}, 64'd0);
    send(PAT);
    check("pat2_samp", {63'd0, samp_done}, 64'd1);
    idle();
    check("pat2_samp_pulse", {63'd0, samp_done}, 64'd0);

    // Pattern, non-pattern, pattern, pattern
    do_reset();
    send(PAT);
    check("ppnp_w1", {63'd0, samp_done}, 64'd0);
    send(64'h1234_5678_0000_0001);
    check("ppnp_w2", {63'd0, samp_done}, 64'd0);
    send(PAT);
    check("ppnp_w3", {63'd0, samp_done}, 64'd0);
    send(PAT);
    check("ppnp_w4", {63'd0, samp_done}, 64'd1);

    // Pattern in ST_HDR is ignored
    send(PAT);
    check("hdr_pat_quiet", {60'd0, samp_done, msg_valid, parity_err, decode_err}, 64'd0);

    // SBINIT done resp, no data
    send(mk_hdr(OPC_MSG_NODATA, 8'h9A, 8'h01, 16'hBEEF, 1'b0));
    check("resp_valid", {63'd0, msg_valid}, 64'd1);
    check("resp_no", {60'd0, msg_no}, 64'd2);
    check("resp_rsp", {63'd0, rsp_delivered}, 64'd1);
    check("resp_info", {48'd0, msg_info}, 64'hBEEF);
    check("resp_dv", {63'd0, data_valid}, 64'd0);
    idle();
    check("resp_valid_pulse", {62'd0, msg_valid, rsp_delivered}, 64'd0);
    check("resp_no_hold", {60'd0, msg_no}, 64'd2);

    // SBINIT done req
    send(mk_hdr(OPC_MSG_NODATA, 8'h95, 8'h01, 16'h0042, 1'b0));
    check("req_valid_rsp", {62'd0, msg_valid, rsp_delivered}, 64'b10);
    check("req_no", {60'd0, msg_no}, 64'd1);

    // CP flipped, then a good header
    w = mk_hdr(OPC_MSG_NODATA, 8'h9A, 8'h01, 16'h0000, 1'b0);
    w[63] = ~w[63];
    send(w);
    check("cp_perr", {63'd0, parity_err}, 64'd1);
    check("cp_no_valid", {63'd0, msg_valid}, 64'd0);
    send(mk_hdr(OPC_MSG_NODATA, 8'h91, 8'h00, 16'h0007, 1'b0));
    check("oor_valid", {63'd0, msg_valid}, 64'd1);
    check("oor_no", {60'd0, msg_no}, 64'd3);
    check("oor_rsp", {63'd0, rsp_delivered}, 64'd0);

    // Table miss and unknown opcode
    send(mk_hdr(OPC_MSG_NODATA, 8'h95, 8'h07, 16'h0000, 1'b0));
    check("miss_derr", {62'd0, decode_err, msg_valid}, 64'b10);
    check("miss_no_hold", {60'd0, msg_no}, 64'd3);
    send(mk_hdr(5'b00001, 8'h95, 8'h01, 16'h0000, 1'b0));
    check("opc_derr", {62'd0, decode_err, msg_valid}, 64'b10);

    // MBINIT PARAM with data (0x1234 has odd weight, so DP=1)
    state = MBINIT;
    sub_state = 4'(PARAM);
    idle();
    send(mk_hdr(OPC_MSG_DATA, 8'hA5, 8'h00, 16'h00C3, 1'b1));
    check("wd_hdr_no_valid", {63'd0, msg_valid}, 64'd0);
    send(64'h1234);
    check("wd_valid", {62'd0, msg_valid, data_valid}, 64'b11);
    check("wd_no", {60'd0, msg_no}, 64'd1);
    check("wd_data", {48'd0, data_bus}, 64'h1234);
    check("wd_info", {48'd0, msg_info}, 64'h00C3);
    check("wd_rsp", {63'd0, rsp_delivered}, 64'd0);
    idle();
    check("wd_dv_pulse", {63'd0, data_valid}, 64'd0);
    check("wd_data_hold", {48'd0, data_bus}, 64'h1234);

    // DP error drops the message
    send(mk_hdr(OPC_MSG_DATA, 8'hA5, 8'h00, 16'h0000, 1'b0));
    send(64'h1234);
    check("dp_perr", {62'd0, parity_err, msg_valid}, 64'b10);

    // Abort between header and data
    send(mk_hdr(OPC_MSG_DATA, 8'hA5, 8'h00, 16'h0000, 1'b1));
    state = MBTRAIN;
    idle();
    state = MBINIT;
    idle();
    send(mk_hdr(OPC_MSG_NODATA, 8'hAA, 8'h00, 16'h5A5A, 1'b0));
    check("abort_valid", {62'd0, msg_valid, data_valid}, 64'b10);
    check("abort_no", {60'd0, msg_no}, 64'd2);
    check("abort_rsp", {63'd0, rsp_delivered}, 64'd1);

    // CAL done resp
    sub_state = 4'(CAL);
    send(mk_hdr(OPC_MSG_NODATA, 8'h9A, 8'h02, 16'h0000, 1'b0));
    check("cal_resp", {58'd0, msg_no, msg_valid, rsp_delivered}, {58'd0, 4'd2, 2'b11});

    // State change in the same cycle as a word: word dropped, back to hunting
    state = SBINIT;
    send(mk_hdr(OPC_MSG_NODATA, 8'h9A, 8'h01, 16'h0000, 1'b0));
    check("same_cycle_abort", {61'd0, msg_valid, parity_err, decode_err}, 64'd0);
    send(PAT);
    send(PAT);
    check("rehunt_samp", {63'd0, samp_done}, 64'd1);

    // Reset in the middle of a with-data message
    send(mk_hdr(OPC_MSG_DATA, 8'h91, 8'h00, 16'h0000, 1'b1));
    rst = 1'b1;
    send(64'h1234);
    check("midrst_out", {29'd0, msg_valid, data_valid, msg_no, data_bus, msg_info},
          64'd0);
    rst = 1'b0;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sb_rx_wrapper.md
# sb_rx_wrapper

Sideband receive-side wrapper: the far-end counterpart of the sideband TX wrapper. It accepts 64-bit words from the sideband deserializer and hunts for the SBINIT clock pattern. It decodes UCIe sideband message headers (plus an optional 64-bit data payload) into the `msg_no`/`msg_info`/data form the LTSM and TX wrapper consume. It raises `o_rx_sb_pattern_samp_done` and `o_rx_sb_rsp_delivered`, the handshakes the TX wrapper waits on.

## Interface
Parameters:
- `PATTERN`, default `64'hAAAA_AAAA_AAAA_AAAA`: SBINIT clock pattern word.
- `PAT_COUNT`, default 2: consecutive pattern words required.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  clock
- `i_rst`  in  1  synchronous, active-high reset
- `i_de_ser_done`  in  1  `i_deser_data` holds a new word this cycle
- `i_deser_data`  in  64  received sideband word
- `i_state`  in  `e_states`  current LTSM state
- `i_sub_state`  in  4  current sub-state (`e_sub_states_MBINIT` while in MBINIT)
- `o_rx_sb_pattern_samp_done`  out  1  one-cycle pulse: pattern detected
- `o_msg_valid`  out  1  one-cycle pulse: decoded message available
- `o_msg_no`  out  4  message enum value for the current state/sub-state
- `o_msg_info`  out  16  raw MsgInfo field
- `o_data_valid`  out  1  high with `o_msg_valid` when the message carried data
- `o_data_bus`  out  16  payload bits [15:0]
- `o_rx_sb_rsp_delivered`  out  1  one-cycle pulse, decoded message is a `*_RESP`
- `o_parity_err`  out  1  one-cycle pulse, CP/DP mismatch
- `o_decode_err`  out  1  one-cycle pulse, unknown opcode or code pair

## Operation
Header fields:
- opcode is [4:0]: `5'b10010` means message without data; `5'b11011` means message with 64-bit data.
- MsgCode is [21:14]; MsgSubcode is [39:32]; MsgInfo is [55:40].
- DP is [62] and covers the data word; CP is [63] and covers header bits [61:0]. Parity is even (XOR of the covered bits equals the parity bit).

FSM states:
- `ST_HUNT`: entered when `i_state==SBINIT` and no pattern has been seen.
  - A word equal to `PATTERN` increments `pat_cnt`.
  - A non-pattern word clears `pat_cnt`.
  - When `pat_cnt` reaches `PAT_COUNT`: pulse `samp_done`, clear `pat_cnt`, go to `ST_HDR`.
- `ST_HDR`:
  - Check CP. On a mismatch, pulse `o_parity_err`, drop the word, stay.
  - Opcode no-data: decode and deliver.
  - Opcode with-data: latch the header, go to `ST_DATA`.
  - Any other opcode: pulse `o_decode_err`, stay.
  - A `PATTERN` word here is ignored silently, since the remote may still be sending the pattern.
- `ST_DATA`: the next accepted word is the payload.
  - DP error: pulse `o_parity_err`, drop the message.
  - Otherwise deliver with `o_data_valid=1`.
  - Either way, return to `ST_HDR`.

Decode: (`i_state`, `i_sub_state`, MsgCode, MsgSubcode) is looked up in the package table:
- SBINIT out-of-reset: 91h/00h → 3
- SBINIT done req: 95h/01h → 1
- SBINIT done resp: 9Ah/01h → 2
- PARAM config req: A5h/00h → 1
- PARAM config resp: AAh/00h → 2
- CAL done req: 95h/02h → 1
- CAL done resp: 9Ah/02h → 2
- A miss pulses `o_decode_err` and delivers nothing.
- The table flags even `msg_no` (`*_RESP`) entries; delivering one of these also pulses `o_rx_sb_rsp_delivered`.

Other rules:
- A change of `i_state` aborts any partial message. The FSM goes to `ST_HUNT` if the new state is SBINIT, otherwise to `ST_HDR`.
- Cycles with `i_de_ser_done=0` do not advance the FSM.

## Timing
- Reset: every output is 0; FSM is in `ST_HUNT`; `pat_cnt=0`.
- Reset asserted mid-message discards the message; outputs are 0 at the next edge.
- All outputs are registered. Latency is 1 cycle from the deciding word's `i_de_ser_done` cycle:
  - the second pattern word;
  - the header word for a no-data message;
  - the data word for a with-data message.
- `o_msg_no`, `o_msg_info` and `o_data_bus` hold their values until the next delivery. `o_data_valid` is a pulse.
- Back-to-back words on consecutive cycles are fully supported; there is no backpressure.
- If the abort condition (`i_state` changed) occurs in the same cycle as `i_de_ser_done`, the abort wins and the word is dropped.

## Structure
- Shared package `sb_pkg`:
  - `e_states`, `e_sub_states_MBINIT`, and the sideband message enums;
  - opcode constants;
  - field bit positions;
  - the decode table as a function `sb_decode(state, sub_state, code, subcode)` returning {hit, msg_no, is_resp}.
- One sub-module, `sb_rx_parity_chk`: combinational CP/DP check, also reused by the TX generator's self-check.

## Test plan
- Reset, `i_state=SBINIT`, two consecutive `PATTERN` words → `o_rx_sb_pattern_samp_done` pulses 1 cycle after the second word; FSM is in `ST_HDR`.
- Pattern, non-pattern, pattern, pattern → exactly one pulse, after the 4th word.
- SBINIT header 9Ah/01h, opcode 10010, correct CP → `o_msg_valid=1`, `o_msg_no=2`, `o_rx_sb_rsp_delivered=1`.
- `i_state=MBINIT`, sub_state PARAM: header A5h/00h with opcode 11011, then data word `64'h1234` → `o_msg_valid=1`, `o_data_valid=1`, `o_msg_no=1`, `o_data_bus=16'h1234`, all 1 cycle after the data word.
- Header with CP flipped → `o_parity_err` pulse, no `o_msg_valid`; a following valid header decodes normally.
- With-data header, then `i_state` changes before the data word → no delivery; the next word is treated as a header.
